// File: rtl/iic_req_arbiter_if.sv
// Bundles the two client request/response channels and the IIC engine
// command channel seen by iic_req_arbiter.
interface iic_req_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic        req0_rw;
    logic [12:0] req0_addr;
    logic [7:0]  req0_wdata;
    logic        rsp0_valid;
    logic [7:0]  rsp0_rdata;
    logic        rsp0_err;

    logic        req1_valid;
    logic        req1_ready;
    logic        req1_rw;
    logic [12:0] req1_addr;
    logic [7:0]  req1_wdata;
    logic        rsp1_valid;
    logic [7:0]  rsp1_rdata;
    logic        rsp1_err;

    logic        iic_en;
    logic        write;
    logic        read;
    logic [7:0]  cs_bit;
    logic [12:0] byte_address;
    logic [7:0]  write_data;
    logic [7:0]  read_data;
    logic        done;
    logic        arb_busy;

    // Environment side: both clients plus the IIC engine.
    modport master (
        output req0_valid, req0_rw, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_rw, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  iic_en, write, read, cs_bit, byte_address, write_data, arb_busy,
        output read_data, done
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_rw, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_rw, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output iic_en, write, read, cs_bit, byte_address, write_data, arb_busy,
        input  read_data, done
    );
endinterface

// File: rtl/iic_req_arbiter.sv
// Two-client round-robin arbiter / command sequencer for the IIC EEPROM engine.
// Optional WAIT watchdog enabled by defining IIC_ARB_TIMEOUT_EN.
module iic_req_arbiter #(
    parameter logic [7:0]  DEV_ADDR       = 8'hA0,
    parameter int unsigned TIMEOUT_CYCLES = 200_000
) (
    input logic              sys_clk,
    input logic              sys_rst,
    iic_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic        last_q;
    logic        gnt_q;
    logic        rw_q;
    logic        iic_en_q;
    logic        write_q;
    logic        read_q;
    logic [12:0] addr_q;
    logic [7:0]  wdata_q;
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [7:0]  rsp0_rdata_q;
    logic [7:0]  rsp1_rdata_q;

    logic        gnt_d;
    logic        accept;
    logic        sel_rw;
    logic [12:0] sel_addr;
    logic [7:0]  sel_wdata;
    logic [7:0]  rdata_d;

    // A tie goes to the port not granted last; a lone requester always wins.
    always_comb begin
        gnt_d = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_d = ~last_q;
        end else if (bus.req1_valid) begin
            gnt_d = 1'b1;
        end
        accept    = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid);
        sel_rw    = gnt_d ? bus.req1_rw    : bus.req0_rw;
        sel_addr  = gnt_d ? bus.req1_addr  : bus.req0_addr;
        sel_wdata = gnt_d ? bus.req1_wdata : bus.req0_wdata;
        rdata_d   = rw_q ? bus.read_data : 8'h00;
    end

`ifdef IIC_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic          rsp0_err_q;
    logic          rsp1_err_q;
`else
    if (TIMEOUT_CYCLES == 0) begin : g_no_watchdog
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            gnt_q        <= 1'b0;
            rw_q         <= 1'b0;
            iic_en_q     <= 1'b0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
`ifdef IIC_ARB_TIMEOUT_EN
            cnt_q        <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
`endif
        end else begin
            iic_en_q     <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        gnt_q    <= gnt_d;
                        rw_q     <= sel_rw;
                        write_q  <= ~sel_rw;
                        read_q   <= sel_rw;
                        addr_q   <= sel_addr;
                        wdata_q  <= sel_rw ? 8'h00 : sel_wdata;
                        iic_en_q <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef IIC_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.done) begin
                        if (gnt_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_rdata_q <= rdata_d;
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_rdata_q <= rdata_d;
                        end
                        state_q <= S_RESP;
`ifdef IIC_ARB_TIMEOUT_EN
                    end else if (cnt_q == CNT_LAST) begin
                        if (gnt_q) begin
                            rsp1_valid_q <= 1'b1;
                            rsp1_rdata_q <= 8'h00;
                            rsp1_err_q   <= 1'b1;
                        end else begin
                            rsp0_valid_q <= 1'b1;
                            rsp0_rdata_q <= 8'h00;
                            rsp0_err_q   <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    last_q  <= gnt_q;
                    write_q <= 1'b0;
                    read_q  <= 1'b0;
`ifdef IIC_ARB_TIMEOUT_EN
                    rsp0_err_q <= 1'b0;
                    rsp1_err_q <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req0_ready   = accept && !gnt_d;
    assign bus.req1_ready   = accept && gnt_d;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp0_rdata   = rsp0_rdata_q;
    assign bus.rsp1_rdata   = rsp1_rdata_q;
`ifdef IIC_ARB_TIMEOUT_EN
    assign bus.rsp0_err     = rsp0_err_q;
    assign bus.rsp1_err     = rsp1_err_q;
`else
    assign bus.rsp0_err     = 1'b0;
    assign bus.rsp1_err     = 1'b0;
`endif
    assign bus.iic_en       = iic_en_q;
    assign bus.write        = write_q;
    assign bus.read         = read_q;
    assign bus.cs_bit       = DEV_ADDR;
    assign bus.byte_address = addr_q;
    assign bus.write_data   = wdata_q;
    assign bus.arb_busy     = (state_q != S_IDLE);

endmodule

// File: doc/iic_req_arbiter.md
# iic_req_arbiter

Two-port round-robin arbiter and command sequencer placed in front of the single IIC EEPROM master engine. It accepts read/write byte requests from two independent clients, grants one at a time, and drives the engine's command interface (`iic_en`, `write`/`read`, address, data). It then waits for the engine's `done` pulse and returns read data and status to the granted client. Only the arbiter drives the engine, so all IIC traffic in the design is serialized here.

## Interface
Parameters:
- `DEV_ADDR`, 8'hA0, device-address byte presented on `cs_bit` for every transaction.
- `TIMEOUT_CYCLES`, 200_000, `WAIT` watchdog limit in `sys_clk` cycles; used only with `IIC_ARB_TIMEOUT_EN`.

Ports:
- `sys_clk` in 1: single clock.
- `sys_rst` in 1: reset, synchronous, active-high.
- `req0_valid` in 1: client 0 request pending.
- `req0_ready` out 1: client 0 request accepted this cycle.
- `req0_rw` in 1: client 0 operation, 1 = read, 0 = write.
- `req0_addr` in 13: client 0 byte address.
- `req0_wdata` in 8: client 0 write data.
- `rsp0_valid` out 1: client 0 response strobe.
- `rsp0_rdata` out 8: client 0 read data.
- `rsp0_err` out 1: client 0 timeout flag.
- `req1_*`, `rsp1_*`: identical to port 0 for client 1.
- `iic_en` out 1: start pulse to the engine.
- `write` out 1: engine write command.
- `read` out 1: engine read command.
- `cs_bit` out 8: engine device address; constant `DEV_ADDR`.
- `byte_address` out 13: engine byte address.
- `write_data` out 8: engine write data.
- `read_data` in 8: engine read result.
- `done` in 1: engine one-cycle completion pulse.
- `arb_busy` out 1: high in any state other than `IDLE`.

## Operation
FSM states:
- `IDLE`
  - If either `reqN_valid` is high, select a winner by round robin: the port not granted last wins a tie, and a lone requester always wins.
  - Assert the winner's `reqN_ready` combinationally for this cycle only.
  - Latch `rw`, `addr`, `wdata` and the grant index.
  - Go to `ISSUE`.
- `ISSUE`
  - `iic_en`=1 for exactly one cycle.
  - `write`=~rw and `read`=rw.
  - Go to `WAIT`.
- `WAIT`
  - Hold `write`, `read`, `byte_address` and `write_data` stable; `iic_en`=0.
  - On `done`: latch `read_data` (write ops latch 8'h00) and go to `RESP`.
- `RESP`
  - Granted `rspN_valid`=1 for one cycle, with `rspN_rdata` and `rspN_err`.
  - Update the last-grant pointer.
  - Clear `write`/`read`.
  - Go to `IDLE`.

Data and event rules:
- `write_data` is driven 8'h00 for read ops.
- `rspN_rdata` holds its last value between strobes.
- `done` outside `WAIT` is ignored.
- A client must hold `valid` and its fields until `ready`. Dropping `valid` before `ready` withdraws the request without error.
- Both clients valid every cycle: grants strictly alternate 0,1,0,1.

## Timing
- Accept at cycle T, then `iic_en` at T+1, then `WAIT` from T+2.
- `done` at cycle D gives `rspN_valid` at D+1. The next accept is possible at D+2.
- Minimum arbiter overhead: 3 cycles per transaction plus engine time.

Reset (any cycle, including mid-transaction):
- State goes to `IDLE`; the pointer is set so port 0 wins the first tie.
- All outputs are 0 except `cs_bit`=`DEV_ADDR`.
- The engine must be reset by the same reset; the in-flight transaction is dropped with no response.

## Configuration
- `IIC_ARB_TIMEOUT_EN` defined:
  - A cycle counter runs in `WAIT`, clears on entry, and saturates.
  - If `done` has not arrived by cycle `TIMEOUT_CYCLES`-1 of `WAIT`, go to `RESP` with `rspN_err`=1 and `rspN_rdata`=8'h00.
  - `done` in that same cycle takes priority: `err`=0.
- Not defined:
  - No counter exists; `WAIT` waits indefinitely.
  - `rsp0_err` and `rsp1_err` are tied 0.

## Test plan
- Client 0 write of addr 13'h0123, data 8'h5A: one `iic_en` pulse; `write`=1, `byte_address`=13'h0123, `write_data`=8'h5A stable until `done`; `rsp0_valid` one cycle after `done`, `err`=0.
- Client 1 read of addr 13'h1FFF; engine model returns 8'hC3: `read`=1, `rsp1_rdata`=8'hC3, `rsp1_valid` one cycle after `done`.
- Both clients valid continuously for 4 transactions: grant order 0,1,0,1, and exactly one `iic_en` per transaction.
- Reset during `WAIT`: outputs return to 0 next cycle with no `rsp` strobe; the first tie after reset grants port 0.
- Stray `done` while in `IDLE`: no response strobe and no state change.
- With `IIC_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `done` withheld: `rspN_err`=1 and `rdata`=8'h00 exactly 16 cycles after `WAIT` entry, then back to `IDLE`.
